// File: rtl/sr_pkg.sv
// Shared SR command encodings and the debounce FSM state type for the
// sr_cmd_debounce front end.
package sr_pkg;

  localparam logic [1:0] SR_HOLD   = 2'b00;
  localparam logic [1:0] SR_RESET  = 2'b01;
  localparam logic [1:0] SR_SET    = 2'b10;
  localparam logic [1:0] SR_FORBID = 2'b11;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b10,
    CHK_LO    = 2'b11
  } deb_state_t;

endpackage

// File: rtl/sr_debounce_ch.sv
// One button channel: 2-flop synchroniser followed by a counting debounce FSM.
// The debounced level flips only after DEB_CYCLES consecutive opposite samples.
module sr_debounce_ch
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEB_CYCLES);
  localparam bit               FAST_FLIP = (DEB_CYCLES == 1);

  logic             sync1_r;
  logic             sync2_r;
  deb_state_t       state_r;
  deb_state_t       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Synchroniser for the asynchronous button input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // FSM state and qualification counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= STABLE_LO;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; any sample at the old level restarts qualification
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      STABLE_LO: begin
        if (sync2_r) begin
          if (FAST_FLIP) begin
            state_s = STABLE_HI;
            cnt_s   = '0;
          end else begin
            state_s = CHK_HI;
            cnt_s   = CNT_ONE;
          end
        end else begin
          cnt_s = '0;
        end
      end
      CHK_HI: begin
        if (!sync2_r) begin
          state_s = STABLE_LO;
          cnt_s   = '0;
        end else if (cnt_inc_s == CNT_LIMIT) begin
          state_s = STABLE_HI;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      STABLE_HI: begin
        if (!sync2_r) begin
          if (FAST_FLIP) begin
            state_s = STABLE_LO;
            cnt_s   = '0;
          end else begin
            state_s = CHK_LO;
            cnt_s   = CNT_ONE;
          end
        end else begin
          cnt_s = '0;
        end
      end
      CHK_LO: begin
        if (sync2_r) begin
          state_s = STABLE_HI;
          cnt_s   = '0;
        end else if (cnt_inc_s == CNT_LIMIT) begin
          state_s = STABLE_LO;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s = STABLE_LO;
        cnt_s   = '0;
      end
    endcase
  end

  // Debounced level decode: high while stable high or still qualifying a release
  always_comb begin
    level = 1'b0;
    case (state_r)
      STABLE_HI: level = 1'b1;
      CHK_LO:    level = 1'b1;
      default:   level = 1'b0;
    endcase
  end

endmodule

// File: rtl/sr_cmd_debounce.sv
// Debounced set/reset buttons combined into a registered SR command with a
// forbidden-state guard. Define SR_ALLOW_FORBIDDEN_EN to pass SR = 11 through.
module sr_cmd_debounce
  import sr_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_raw,
  input  logic       reset_raw,
  output logic [1:0] SR,
  output logic       sr_chg,
  output logic       conflict
);

  logic       ds_s;
  logic       dr_s;
  logic [1:0] sr_s;
  logic       conflict_s;

  sr_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_set_ch (
    .clk   (clk),
    .rst   (rst),
    .raw   (set_raw),
    .level (ds_s)
  );

  sr_debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_reset_ch (
    .clk   (clk),
    .rst   (rst),
    .raw   (reset_raw),
    .level (dr_s)
  );

  // Combine debounced levels into the next command, guarding set+reset
  always_comb begin
    sr_s       = SR_HOLD;
    conflict_s = 1'b0;
    case ({ds_s, dr_s})
      2'b00: sr_s = SR_HOLD;
      2'b01: sr_s = SR_RESET;
      2'b10: sr_s = SR_SET;
      2'b11: begin
        conflict_s = 1'b1;
`ifdef SR_ALLOW_FORBIDDEN_EN
        sr_s = SR_FORBID;
`else
        sr_s = SR_HOLD;
`endif
      end
      default: begin
        sr_s       = SR_HOLD;
        conflict_s = 1'b0;
      end
    endcase
  end

  // Output registers; the change strobe compares next against current command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SR       <= SR_HOLD;
      sr_chg   <= 1'b0;
      conflict <= 1'b0;
    end else begin
      SR       <= sr_s;
      sr_chg   <= (sr_s != SR);
      conflict <= conflict_s;
    end
  end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Self-checking bench for sr_cmd_debounce: per-cycle scoreboard fed by a
// history-window reference model, plus directed latency checks.
module tb_sr_cmd_debounce;

  localparam int DEB = 4;
`ifdef SR_ALLOW_FORBIDDEN_EN
  localparam logic [1:0] EXP_BOTH = 2'b11;
`else
  localparam logic [1:0] EXP_BOTH = 2'b00;
`endif
  // First edge at which a change is visible, counting the edge after the input move as 1
  localparam int EXP_LAT = DEB + 3;

  logic       clk;
  logic       rst;
  logic       set_raw;
  logic       reset_raw;
  logic [1:0] SR;
  logic       sr_chg;
  logic       conflict;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [1:0]     m_s1;
  logic [1:0]     m_s2;
  logic [DEB-1:0] m_h [2];
  logic [1:0]     m_lvl;
  logic [1:0]     m_sr;
  logic [3:0]     sb_q [$];

  sr_cmd_debounce #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_raw   (set_raw),
    .reset_raw (reset_raw),
    .SR        (SR),
    .sr_chg    (sr_chg),
    .conflict  (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a level flips once the last DEB synchronised samples all oppose it
  task automatic model_edge();
    logic [1:0]     nsr;
    logic           chg;
    logic           conf;
    logic [DEB-1:0] h;
    if (rst) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00; m_sr = 2'b00;
      m_h[0] = '0; m_h[1] = '0;
      sb_q.push_back(4'b0000);
    end else begin
      conf = m_lvl[1] & m_lvl[0];
      nsr  = conf ? EXP_BOTH : m_lvl;
      chg  = (nsr != m_sr);
      m_sr = nsr;
      for (int c = 0; c < 2; c++) begin
        h = {m_h[c][DEB-2:0], m_s2[c]};
        if (!m_lvl[c] && (&h)) m_lvl[c] = 1'b1;
        else if (m_lvl[c] && (h == '0)) m_lvl[c] = 1'b0;
        m_h[c] = h;
      end
      m_s2 = m_s1;
      m_s1 = {set_raw, reset_raw};
      sb_q.push_back({nsr, chg, conf});
    end
  endtask

  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    model_edge();
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_sr", {6'd0, SR}, {6'd0, e[3:2]});
      check_eq("sb_chg", {7'd0, sr_chg}, {7'd0, e[1]});
      check_eq("sb_conflict", {7'd0, conflict}, {7'd0, e[0]});
    end
  endtask

  // Step until sr_chg (or conflict) is seen; n = edges taken, capped at max
  task automatic wait_evt(input bit use_conf, input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      step();
      n++;
      if (use_conf ? conflict : sr_chg) break;
    end
  endtask

  initial begin
    int n;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; set_raw = 1'b1; reset_raw = 1'b1;

    // Reset held with both buttons pressed
    repeat (2) begin
      step();
      check_eq("rst_sr", {6'd0, SR}, 8'd0);
      check_eq("rst_chg", {7'd0, sr_chg}, 8'd0);
      check_eq("rst_conflict", {7'd0, conflict}, 8'd0);
    end
    rst = 1'b0; set_raw = 1'b0; reset_raw = 1'b0;
    repeat (3) step();

    // Clean press and release of set
    set_raw = 1'b1;
    wait_evt(1'b0, 20, n);
    check_eq("set_lat", 8'(n), 8'(EXP_LAT));
    check_eq("set_sr", {6'd0, SR}, 8'h02);
    step();
    check_eq("set_pulse_once", {7'd0, sr_chg}, 8'd0);
    repeat (3) step();
    set_raw = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("set_rel_lat", 8'(n), 8'(EXP_LAT));
    check_eq("set_rel_sr", {6'd0, SR}, 8'h00);
    repeat (2) step();

    // Bounce: 3 high, 1 low, then held high
    set_raw = 1'b1;
    repeat (3) step();
    set_raw = 1'b0;
    step();
    set_raw = 1'b1;
    wait_evt(1'b0, 20, n);
    check_eq("bounce_lat", 8'(n + 4), 8'd11);
    check_eq("bounce_sr", {6'd0, SR}, 8'h02);

    // Set held, reset added: guard engages
    reset_raw = 1'b1;
    wait_evt(1'b0, 20, n);
    check_eq("both_lat", 8'(n), 8'(EXP_LAT));
    check_eq("both_sr", {6'd0, SR}, {6'd0, EXP_BOTH});
    check_eq("both_conflict", {7'd0, conflict}, 8'd1);
    reset_raw = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("unboth_sr", {6'd0, SR}, 8'h02);
    check_eq("unboth_conflict", {7'd0, conflict}, 8'd0);
    set_raw = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("idle_sr", {6'd0, SR}, 8'h00);
    repeat (2) step();

    // Reset pulse mid-qualification discards progress
    reset_raw = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    check_eq("midrst_sr", {6'd0, SR}, 8'h00);
    rst = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("midrst_lat", 8'(n), 8'(EXP_LAT));
    check_eq("midrst_sr2", {6'd0, SR}, 8'h01);
    reset_raw = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("midrst_rel", {6'd0, SR}, 8'h00);
    repeat (2) step();

    // Simultaneous press, then set drops
    set_raw = 1'b1; reset_raw = 1'b1;
    wait_evt(1'b1, 20, n);
    check_eq("sim_lat", 8'(n), 8'(EXP_LAT));
    check_eq("sim_sr", {6'd0, SR}, {6'd0, EXP_BOTH});
    set_raw = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("drop_lat", 8'(n), 8'(EXP_LAT));
    check_eq("drop_sr", {6'd0, SR}, 8'h01);
    check_eq("drop_conflict", {7'd0, conflict}, 8'd0);
    reset_raw = 1'b0;
    wait_evt(1'b0, 20, n);
    check_eq("final_sr", {6'd0, SR}, 8'h00);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_cmd_debounce.md
# sr_cmd_debounce

Front-end stage that converts two raw, asynchronous push-button inputs (set and reset) into a clean, registered 2-bit SR command for the `sr_ff` stage directly downstream. Each button is synchronised and debounced, and the results are combined into the SR encoding. A forbidden-state guard blocks simultaneous set+reset from reaching the flip-flop. A one-cycle change strobe marks every command update for downstream logging or counting.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced level flips; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of each channel's debounce counter.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `set_raw`  input  1: raw set button; asynchronous to `clk` and may bounce.
- `reset_raw`  input  1: raw reset button; asynchronous to `clk` and may bounce.
- `SR`  output  2: registered command to `sr_ff`. `SR[1]` is S and `SR[0]` is R. 00 = hold, 01 = reset, 10 = set, 11 = forbidden.
- `sr_chg`  output  1: one-cycle pulse, high during the first cycle in which `SR` holds a new value.
- `conflict`  output  1: registered; high while both debounced levels are high.

## Operation
- Per channel, a 2-flop synchroniser feeds a 4-state FSM: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
- STABLE_x state:
  - If the synchronised sample equals the debounced level, stay and keep the counter at 0.
  - If it differs, go to CHK_y and set the counter to 1.
  - If DEB_CYCLES = 1, flip straight to STABLE_y instead.
- CHK_y state:
  - A sample at level y increments the counter.
  - When the counter reaches DEB_CYCLES, go to STABLE_y (debounced level = y) and clear the counter.
  - A sample at the old level returns to STABLE_x and clears the counter. Any bounce restarts qualification from zero.
- Debounced level is 1 in STABLE_HI and CHK_LO, and 0 otherwise.
- Command combine, registered, using debounced set `ds` and debounced reset `dr`:
  - `{ds,dr}` = 00, 01 or 10 drives `SR` = `{ds,dr}` and `conflict` = 0.
  - `{ds,dr}` = 11 drives `conflict` = 1, and `SR` = 00 (see Configuration).
- `sr_chg` is registered alongside `SR`: high for exactly one cycle when the next `SR` differs from the current `SR`, low otherwise.
- Reset values: `SR` = 00, `sr_chg` = 0, `conflict` = 0, all synchroniser flops 0, both FSMs in STABLE_LO, both counters 0.
- Reset asserted mid-qualification discards all progress immediately. After release, a button still held high needs the full latency again.

## Timing
- Raw input stable from before rising edge N: the synchroniser output changes after edge N+1.
- The debounced level flips at edge N+1+DEB_CYCLES.
- `SR`, `conflict` and `sr_chg` update at edge N+2+DEB_CYCLES. Total latency is DEB_CYCLES+2 edges; with the default this is 6.
- The two channels are independent. If both qualify on the same edge, the combine sees both new levels together: no intermediate `SR` value and a single `sr_chg` pulse.
- Both debounced levels at 1 (channels still independent): `SR` goes to 00 or 11 per Configuration, with one `sr_chg` pulse if the value changed.
- Release to 00 is debounced with the same latency as press.
- No backpressure: the downstream stage samples `SR` every cycle.

## Configuration
- `SR_ALLOW_FORBIDDEN_EN` defined: `{ds,dr}` = 11 drives `SR` = 11, which lets the bench exercise the flip-flop's forbidden state. `conflict` is still asserted.
- Not defined (default): `{ds,dr}` = 11 drives `SR` = 00 with `conflict` = 1.
- No other behaviour changes between the two builds.

## Structure
- Shared package `sr_pkg` holds:
  - The SR encoding constants `SR_HOLD` = 00, `SR_RESET` = 01, `SR_SET` = 10, `SR_FORBID` = 11.
  - The debounce FSM state typedef (STABLE_LO, CHK_HI, STABLE_HI, CHK_LO).
- One sub-module, `sr_debounce_ch`, contains the synchroniser, the FSM and the counter. It is instantiated twice.
- The top level holds only the combine/guard logic and the output registers.

## Test plan
All scenarios use DEB_CYCLES = 4.
- Hold `rst` = 1 for 2 cycles with both raw inputs high -> `SR` = 00, `sr_chg` = 0, `conflict` = 0 throughout reset.
- Raise `set_raw` before edge N and hold -> `SR` = 10 at edge N+6, `sr_chg` high for exactly that one cycle. Releasing it later returns `SR` to 00 six edges after release.
- `set_raw` high 3 cycles, low 1, then high and held -> no change until 4 consecutive clean samples, so `SR` = 10 at edge N+10 counted from the first rise.
- `set_raw` held, then `reset_raw` raised and held -> without the macro, `SR` goes 10 -> 00 with `conflict` = 1 and one `sr_chg` pulse. Built with `SR_ALLOW_FORBIDDEN_EN`, `SR` = 11 and `conflict` = 1.
- `reset_raw` raised, then `rst` pulsed 1 cycle at edge N+4 -> `SR` stays 00, and `SR` = 01 only 6 edges after `rst` deasserts.
- Both raw inputs rise together, then `set_raw` drops -> during overlap `conflict` = 1 and `SR` = 00. After the drop, `SR` = 01 six edges later with `conflict` = 0.
